// File: rtl/scr1_tcap_pkg.sv
// Shared definitions for the timer input-capture unit: dmem encodings,
// register offsets, CTRL/STATUS bit positions and the FIFO entry type.
package scr1_tcap_pkg;

  localparam int unsigned SCR1_DMEM_AWIDTH = 32;

  localparam logic       SCR1_MEM_CMD_RD       = 1'b0;
  localparam logic       SCR1_MEM_CMD_WR       = 1'b1;
  localparam logic [1:0] SCR1_MEM_WIDTH_WORD   = 2'b10;
  localparam logic [1:0] SCR1_MEM_RESP_NOTRDY  = 2'b00;
  localparam logic [1:0] SCR1_MEM_RESP_RDY_OK  = 2'b01;
  localparam logic [1:0] SCR1_MEM_RESP_RDY_ER  = 2'b10;

  localparam logic [4:0] SCR1_TCAP_ADDR_CTRL    = 5'h00;
  localparam logic [4:0] SCR1_TCAP_ADDR_STATUS  = 5'h04;
  localparam logic [4:0] SCR1_TCAP_ADDR_DATA_LO = 5'h08;
  localparam logic [4:0] SCR1_TCAP_ADDR_DATA_HI = 5'h0C;
  localparam logic [4:0] SCR1_TCAP_ADDR_DATA_CH = 5'h10;

  localparam int SCR1_TCAP_CTRL_EN     = 0;
  localparam int SCR1_TCAP_CTRL_IRQ_EN = 1;
  localparam int SCR1_TCAP_CTRL_CH_EN  = 4;
  localparam int SCR1_TCAP_CTRL_POL    = 8;

  localparam int SCR1_TCAP_STATUS_CNT   = 0;
  localparam int SCR1_TCAP_STATUS_EMPTY = 8;
  localparam int SCR1_TCAP_STATUS_FULL  = 9;
  localparam int SCR1_TCAP_STATUS_OVF   = 10;

  typedef struct packed {
    logic [1:0]  ch;
    logic [63:0] ts;
  } type_scr1_tcap_entry_s;

endpackage

// File: rtl/scr1_timer_capture_if.sv
// dmem-style slave bus shared with the memory-mapped timer.
interface scr1_timer_capture_if
  import scr1_tcap_pkg::*;
();
  logic                        dmem_req;
  logic                        dmem_cmd;
  logic [1:0]                  dmem_width;
  logic [SCR1_DMEM_AWIDTH-1:0] dmem_addr;
  logic [31:0]                 dmem_wdata;
  logic                        dmem_req_ack;
  logic [31:0]                 dmem_rdata;
  logic [1:0]                  dmem_resp;

  modport master (
    output dmem_req, dmem_cmd, dmem_width, dmem_addr, dmem_wdata,
    input  dmem_req_ack, dmem_rdata, dmem_resp
  );

  modport slave (
    input  dmem_req, dmem_cmd, dmem_width, dmem_addr, dmem_wdata,
    output dmem_req_ack, dmem_rdata, dmem_resp
  );
endinterface

// File: rtl/scr1_tcap_fifo.sv
// Synchronous capture FIFO; push while full is accepted only alongside a pop,
// pop while empty is ignored.
module scr1_tcap_fifo
  import scr1_tcap_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      push,
  input  logic                      pop,
  input  type_scr1_tcap_entry_s     wdata,
  output type_scr1_tcap_entry_s     rdata,
  output logic                      full,
  output logic                      empty,
  output logic [$clog2(DEPTH):0]    count
);
  localparam int unsigned PTR_W = $clog2(DEPTH);

  type_scr1_tcap_entry_s mem [DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic                  do_push;
  logic                  do_pop;

  assign empty   = (count == '0);
  assign full    = (count == ($clog2(DEPTH)+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem[rd_ptr];

  // NOTE: state registers use <= so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage is not reset; count gates every read, so stale words are never visible.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/scr1_timer_capture.sv
// Input-capture unit: timestamps pin edges with timer_val into a FIFO read over dmem.
// Optional glitch filter on each channel: define SCR1_TCAP_FILTER_EN.
module scr1_timer_capture
  import scr1_tcap_pkg::*;
#(
  parameter int unsigned CAP_CH_NUM = 2,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [CAP_CH_NUM-1:0] cap_in,
  input  logic [63:0]           timer_val,
  scr1_timer_capture_if.slave   dmem_if,
  output logic                  cap_irq
);
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic                  ctrl_en, ctrl_irq_en, ovf;
  logic [CAP_CH_NUM-1:0] ch_en, ch_pol, ch_act;
  logic [CAP_CH_NUM-1:0] sync_ff1, sync_ff2, prev_lvl, cap_lvl, det, edge_q, pend, grant;
  logic [63:0]           hold [CAP_CH_NUM];
  logic                  req_valid, rd_req, wr_req, fifo_pop, push_en;
  logic                  fifo_full, fifo_empty;
  logic [CNT_W-1:0]      fifo_cnt;
  logic [4:0]            addr;
  logic [31:0]           rd_data;
  logic [1:0]            push_ch;
  logic [63:0]           push_ts;
  logic                  unused_bus;
  type_scr1_tcap_entry_s push_entry, head;

  assign addr       = dmem_if.dmem_addr[4:0];
  assign unused_bus = ^{dmem_if.dmem_addr, dmem_if.dmem_wdata};
  assign req_valid  = dmem_if.dmem_req & (dmem_if.dmem_width == SCR1_MEM_WIDTH_WORD)
                    & (addr[1:0] == 2'b00) & (addr <= SCR1_TCAP_ADDR_DATA_CH);
  assign rd_req     = req_valid & (dmem_if.dmem_cmd == SCR1_MEM_CMD_RD);
  assign wr_req     = req_valid & (dmem_if.dmem_cmd == SCR1_MEM_CMD_WR);
  assign fifo_pop   = rd_req & (addr == SCR1_TCAP_ADDR_DATA_HI);
  assign ch_act     = ch_en & {CAP_CH_NUM{ctrl_en}};
  assign dmem_if.dmem_req_ack = 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_ff1 <= '0;
      sync_ff2 <= '0;
      prev_lvl <= '0;
      edge_q   <= '0;
    end else begin
      sync_ff1 <= cap_in;
      sync_ff2 <= sync_ff1;
      prev_lvl <= cap_lvl;
      edge_q   <= det;
    end
  end

`ifdef SCR1_TCAP_FILTER_EN
  logic [CAP_CH_NUM-1:0] hist1, hist2;
  always_ff @(posedge clk) begin
    if (rst) begin
      hist1 <= '0;
      hist2 <= '0;
    end else begin
      hist1 <= sync_ff2;
      hist2 <= hist1;
    end
  end
  // Level moves only when three consecutive samples agree, otherwise it holds.
  assign cap_lvl = (sync_ff2 & hist1 & hist2) | (prev_lvl & (sync_ff2 | hist1 | hist2));
`else
  assign cap_lvl = sync_ff2;
`endif

  assign det = ((cap_lvl & ~prev_lvl & ~ch_pol) | (~cap_lvl & prev_lvl & ch_pol)) & ch_act;

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign push_en = (|pend) & (~fifo_full | (fifo_pop & ~fifo_empty));
  assign grant   = pend & (~pend + 1'b1) & {CAP_CH_NUM{push_en}};

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    push_ch = '0;
    push_ts = '0;
    for (int i = CAP_CH_NUM - 1; i >= 0; i--) begin
      if (pend[i]) begin
        push_ch = 2'(i);
        push_ts = hold[i];
      end
    end
  end

  assign push_entry.ch = push_ch;
  assign push_entry.ts = push_ts;

  always_ff @(posedge clk) begin
    if (rst) begin
      pend <= '0;
      ovf  <= 1'b0;
      for (int i = 0; i < CAP_CH_NUM; i++) hold[i] <= '0;
    end else begin
      for (int i = 0; i < CAP_CH_NUM; i++) begin
        if (!ch_act[i]) begin
          pend[i] <= 1'b0;
        end else if (edge_q[i] && !pend[i]) begin
          pend[i] <= 1'b1;
          hold[i] <= timer_val;
        end else if (grant[i]) begin
          pend[i] <= 1'b0;
        end
      end
      if (|(edge_q & pend & ch_act)) begin
        ovf <= 1'b1;
      end else if (wr_req && addr == SCR1_TCAP_ADDR_STATUS
                   && dmem_if.dmem_wdata[SCR1_TCAP_STATUS_OVF]) begin
        ovf <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_en     <= 1'b0;
      ctrl_irq_en <= 1'b0;
      ch_en       <= '0;
      ch_pol      <= '0;
    end else if (wr_req && addr == SCR1_TCAP_ADDR_CTRL) begin
      ctrl_en     <= dmem_if.dmem_wdata[SCR1_TCAP_CTRL_EN];
      ctrl_irq_en <= dmem_if.dmem_wdata[SCR1_TCAP_CTRL_IRQ_EN];
      ch_en       <= dmem_if.dmem_wdata[SCR1_TCAP_CTRL_CH_EN +: CAP_CH_NUM];
      ch_pol      <= dmem_if.dmem_wdata[SCR1_TCAP_CTRL_POL +: CAP_CH_NUM];
    end
  end

  scr1_tcap_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_en),
    .pop   (fifo_pop),
    .wdata (push_entry),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_cnt)
  );

  always_comb begin
    rd_data = '0;
    case (addr)
      SCR1_TCAP_ADDR_CTRL: begin
        rd_data[SCR1_TCAP_CTRL_EN]                  = ctrl_en;
        rd_data[SCR1_TCAP_CTRL_IRQ_EN]              = ctrl_irq_en;
        rd_data[SCR1_TCAP_CTRL_CH_EN +: CAP_CH_NUM] = ch_en;
        rd_data[SCR1_TCAP_CTRL_POL +: CAP_CH_NUM]   = ch_pol;
      end
      SCR1_TCAP_ADDR_STATUS: begin
        rd_data[SCR1_TCAP_STATUS_CNT +: CNT_W] = fifo_cnt;
        rd_data[SCR1_TCAP_STATUS_EMPTY]        = fifo_empty;
        rd_data[SCR1_TCAP_STATUS_FULL]         = fifo_full;
        rd_data[SCR1_TCAP_STATUS_OVF]          = ovf;
      end
      SCR1_TCAP_ADDR_DATA_LO: if (!fifo_empty) rd_data = head.ts[31:0];
      SCR1_TCAP_ADDR_DATA_HI: if (!fifo_empty) rd_data = head.ts[63:32];
      SCR1_TCAP_ADDR_DATA_CH: if (!fifo_empty) rd_data = {30'b0, head.ch};
      default: rd_data = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dmem_if.dmem_resp  <= SCR1_MEM_RESP_NOTRDY;
      dmem_if.dmem_rdata <= '0;
      cap_irq            <= 1'b0;
    end else begin
      dmem_if.dmem_resp  <= !dmem_if.dmem_req ? SCR1_MEM_RESP_NOTRDY
                          : req_valid         ? SCR1_MEM_RESP_RDY_OK
                          :                     SCR1_MEM_RESP_RDY_ER;
      dmem_if.dmem_rdata <= rd_req ? rd_data : '0;
      cap_irq            <= ctrl_irq_en & ~fifo_empty;
    end
  end

endmodule
